// File: rtl/clp_instr_sched_if.sv
// Instruction BRAM read port plus the valid/ready dispatch channel to the CLP.
// master = scheduler side, slave = BRAM + CLP side.
interface clp_instr_sched_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 64
);
    logic               instr_mem_en;
    logic [ADDR_W-1:0]  instr_mem_addr;
    logic [INSTR_W-1:0] instr_port;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;
    logic               clp_done;

    modport master (
        output instr_mem_en,
        output instr_mem_addr,
        output instr_out,
        output instr_valid,
        input  instr_port,
        input  instr_ready,
        input  clp_done
    );

    modport slave (
        input  instr_mem_en,
        input  instr_mem_addr,
        input  instr_out,
        input  instr_valid,
        output instr_port,
        output instr_ready,
        output clp_done
    );
endinterface

// File: rtl/clp_instr_sched.sv
// Walks the instruction BRAM from address 0 and dispatches each word to the CLP,
// stalling on sync instructions until the CLP reports completion.
module clp_instr_sched #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_enable,
    clp_instr_sched_if.master        bus,
    output logic                     CLP_state,
    output logic                     sched_done,
    output logic [CNT_W-1:0]         instr_count,
    output logic                     err_overflow
);
    localparam int OP_MSB   = INSTR_W - 1;
    localparam int SYNC_BIT = INSTR_W - 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] ireg_q, ireg_d;
    logic [INSTR_W-1:0] out_q, out_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    always_comb begin
        state_d  = state_q;
        mem_en_d = mem_en_q;
        addr_d   = addr_q;
        ireg_d   = ireg_q;
        out_d    = out_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (acc_enable) begin
                    addr_d   = '0;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_en_d = 1'b0;
                state_d  = S_LATCH;
            end
            S_LATCH: begin
                ireg_d  = bus.instr_port;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (ireg_q[OP_MSB -: 4] == 4'h0) begin
                    state_d = S_DONE;
                end else begin
                    out_d   = ireg_q;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    state_d = ireg_q[SYNC_BIT] ? S_WAIT_DONE : S_NEXT;
                end
            end
            // clp_done is only honoured here; pulses elsewhere are dropped on purpose
            S_WAIT_DONE: begin
                if (bus.clp_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (addr_q == '1) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    mem_en_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mem_en_q <= 1'b0;
            addr_q   <= '0;
            ireg_q   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_en_q <= mem_en_d;
            addr_q   <= addr_d;
            ireg_q   <= ireg_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.instr_mem_en   = mem_en_q;
    assign bus.instr_mem_addr = addr_q;
    assign bus.instr_out      = out_q;
    assign bus.instr_valid    = valid_q;
    assign CLP_state          = busy_q;
    assign sched_done         = done_q;
    assign instr_count        = cnt_q;
    assign err_overflow       = ovf_q;
endmodule

// File: tb/tb_clp_instr_sched.sv
// Randomized bench for clp_instr_sched: BRAM model, CLP stimulus and a
// program-level reference model of what should be fetched and dispatched.
module tb_clp_instr_sched;
    logic        clk;
    logic        rst;
    logic        acc_enable;
    logic        CLP_state;
    logic        sched_done;
    logic [15:0] instr_count;
    logic        err_overflow;

    clp_instr_sched_if #(.ADDR_W(10), .INSTR_W(64)) bus ();

    clp_instr_sched #(.ADDR_W(10), .INSTR_W(64), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .acc_enable   (acc_enable),
        .bus          (bus),
        .CLP_state    (CLP_state),
        .sched_done   (sched_done),
        .instr_count  (instr_count),
        .err_overflow (err_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [63:0] mem [1024];
    always @(posedge clk) begin
        if (bus.instr_mem_en) bus.instr_port <= mem[bus.instr_mem_addr];
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] got_q [$];
    int          addr_q [$];
    int          done_cnt, stab_err, cnt_err, sync_err, lat_err;
    int          hs_cnt, trig_cyc, trig_lat;
    bit          trig_ok, awaiting, sync_pend, prev_v, prev_r;
    logic [63:0] prev_out;

    always @(negedge clk) begin
        if (!rst) begin
            awaiting  = 1'b0;
            trig_ok   = 1'b0;
            sync_pend = 1'b0;
            prev_v    = 1'b0;
            prev_r    = 1'b0;
            hs_cnt    = 0;
        end else begin
            if (prev_v && !prev_r && (!bus.instr_valid || bus.instr_out !== prev_out))
                stab_err++;
            if (CLP_state && instr_count !== 16'((hs_cnt > 65535) ? 65535 : hs_cnt))
                cnt_err++;
            if (awaiting && bus.instr_mem_en) sync_err++;
            if (bus.instr_mem_en) addr_q.push_back(int'(bus.instr_mem_addr));
            if (bus.instr_valid && !prev_v) begin
                if (!trig_ok || cyc != trig_cyc + trig_lat) lat_err++;
                trig_ok = 1'b0;
            end
            if (bus.clp_done && awaiting) begin
                awaiting = 1'b0;
                trig_cyc = cyc + 1;
                trig_lat = 4;
                trig_ok  = 1'b1;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                got_q.push_back(bus.instr_out);
                hs_cnt++;
                if (bus.instr_out[59]) begin
                    awaiting  = 1'b1;
                    sync_pend = 1'b1;
                end else begin
                    trig_cyc = cyc + 1;
                    trig_lat = 4;
                    trig_ok  = 1'b1;
                end
            end
            if (!CLP_state && acc_enable) begin
                trig_cyc = cyc + 1;
                trig_lat = 3;
                trig_ok  = 1'b1;
                hs_cnt   = 0;
            end
            if (sched_done) done_cnt++;
            prev_v   = bus.instr_valid;
            prev_r   = bus.instr_ready;
            prev_out = bus.instr_out;
        end
    end

    // ---------------- reference model ----------------
    logic [63:0] exp_q [$];
    int          exp_fetch;
    bit          exp_ovf;

    task automatic ref_model();
        exp_q.delete();
        exp_fetch = 0;
        exp_ovf   = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            exp_fetch = a + 1;
            if (mem[a][63:60] == 4'h0) break;
            exp_q.push_back(mem[a]);
            if (a == 1023) exp_ovf = 1'b1;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 1024; a++) mem[a] = {$urandom, $urandom};
    endtask

    task automatic load_prog(input int n, input bit allow_sync);
        logic [63:0] w;
        fill_random();
        for (int i = 0; i < n; i++) begin
            w        = {$urandom, $urandom};
            w[63:60] = 4'($urandom_range(1, 15));
            w[59]    = allow_sync ? 1'($urandom_range(0, 1)) : 1'b0;
            mem[i]   = w;
        end
        w        = {$urandom, $urandom};
        w[63:60] = 4'h0;
        mem[n]   = w;
    endtask

    // ---------------- stimulus ----------------
    int cd;
    int vh;

    task automatic drive_inputs(input int rmode, input int rpct, input bit noise, input int dly);
        if (bus.instr_valid) vh++; else vh = 0;
        case (rmode)
            0:       bus.instr_ready = 1'b1;
            1:       bus.instr_ready = ($urandom_range(0, 99) < rpct);
            2:       bus.instr_ready = (vh > 5);
            default: bus.instr_ready = 1'b0;
        endcase
        bus.clp_done = 1'b0;
        if (sync_pend) begin
            sync_pend = 1'b0;
            cd = (dly > 0) ? dly : int'($urandom_range(1, 8));
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) bus.clp_done = 1'b1;
        end else if (noise && bus.instr_valid && $urandom_range(0, 2) == 0) begin
            bus.clp_done = 1'b1;
        end
        acc_enable = noise && CLP_state && ($urandom_range(0, 5) == 0);
    endtask

    task automatic run_prog(input string name, input int rmode, input int rpct,
                            input bit noise, input int dly);
        int n;
        int addr_err;
        int exp_cnt;
        ref_model();
        got_q.delete();
        addr_q.delete();
        done_cnt = 0; stab_err = 0; cnt_err = 0; sync_err = 0; lat_err = 0;
        cd = 0; vh = 0; sync_pend = 1'b0;

        @(posedge clk); #1;
        drive_inputs(rmode, rpct, noise, dly);
        acc_enable = 1'b1;
        @(posedge clk); #1;
        drive_inputs(rmode, rpct, noise, dly);
        chk({name, ".busy"}, 64'(CLP_state), 64'd1);
        for (int c = 0; c < 40000 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            drive_inputs(rmode, rpct, noise, dly);
        end
        acc_enable   = 1'b0;
        bus.clp_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, ".n_issued"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({name, ".dispatch"}, got_q[i], exp_q[i]);
        exp_cnt = (exp_q.size() > 65535) ? 65535 : exp_q.size();
        chk({name, ".count"}, 64'(instr_count), 64'(exp_cnt));
        chk({name, ".overflow"}, 64'(err_overflow), 64'(exp_ovf));
        chk({name, ".n_fetch"}, 64'(addr_q.size()), 64'(exp_fetch));
        addr_err = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) addr_err++;
        chk({name, ".addr_seq"}, 64'(addr_err), 64'd0);
        chk({name, ".final_addr"}, 64'(bus.instr_mem_addr), 64'(exp_fetch - 1));
        chk({name, ".idle"}, 64'(CLP_state), 64'd0);
        chk({name, ".stable"}, 64'(stab_err), 64'd0);
        chk({name, ".count_track"}, 64'(cnt_err), 64'd0);
        chk({name, ".sync_hold"}, 64'(sync_err), 64'd0);
        chk({name, ".latency"}, 64'(lat_err), 64'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".en"},    64'(bus.instr_mem_en),   64'd0);
        chk({name, ".addr"},  64'(bus.instr_mem_addr), 64'd0);
        chk({name, ".out"},   bus.instr_out,           64'd0);
        chk({name, ".valid"}, 64'(bus.instr_valid),    64'd0);
        chk({name, ".state"}, 64'(CLP_state),          64'd0);
        chk({name, ".sdone"}, 64'(sched_done),         64'd0);
        chk({name, ".count"}, 64'(instr_count),        64'd0);
        chk({name, ".ovf"},   64'(err_overflow),       64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        acc_enable = 1'b0;
        bus.instr_ready = 1'b0;
        bus.clp_done = 1'b0;
        fill_random();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset");

        fill_random();
        mem[0] = 64'h1000_0000_0000_0001;
        mem[1] = 64'h2000_0000_0000_0002;
        mem[2] = 64'h0;
        run_prog("basic", 0, 100, 1'b0, 0);

        load_prog(3, 1'b0);
        run_prog("backpressure", 2, 0, 1'b0, 0);

        fill_random();
        mem[0] = 64'h1800_0000_0000_00AA;
        mem[1] = 64'h0;
        run_prog("sync", 2, 0, 1'b1, 7);

        for (int r = 0; r < 6; r++) begin
            load_prog(int'($urandom_range(0, 12)), 1'b1);
            run_prog("random", 1, int'($urandom_range(30, 100)), 1'b1, 0);
        end

        for (int a = 0; a < 1024; a++) mem[a] = 64'h1000_0000_0000_0000;
        run_prog("overflow", 0, 100, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("overflow.held_ovf", 64'(err_overflow), 64'd1);
        chk("overflow.held_cnt", 64'(instr_count), 64'd1024);
        #2 rst = 1'b0;
        #1 chk_all_zero("idle_reset");
        @(negedge clk) rst = 1'b1;

        // mid-run async reset while an instruction is held in ISSUE
        load_prog(6, 1'b0);
        @(posedge clk); #1;
        acc_enable = 1'b1;
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        acc_enable = 1'b0;
        for (int c = 0; c < 100; c++) begin
            bus.instr_ready = (instr_count < 16'd2);
            if (instr_count >= 16'd2 && bus.instr_valid) break;
            @(posedge clk); #1;
        end
        chk("midrun.in_issue", 64'(bus.instr_valid), 64'd1);
        chk("midrun.addr", 64'(bus.instr_mem_addr), 64'd2);
        chk("midrun.out", bus.instr_out, mem[2]);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_all_zero("midrun_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        load_prog(4, 1'b1);
        run_prog("restart", 1, 60, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/clp_instr_sched.md
Name: clp_instr_sched

Overview:
- Instruction fetch and dispatch controller between the 64-bit instruction BRAM and the CLP (convolution layer processor).
- On `acc_enable` it walks the instruction memory from address 0. Each instruction is handed to the CLP over a valid/ready handshake.
- Instructions with the sync bit set make the controller wait for CLP completion.
- Stops on an END opcode or on address exhaustion, and drives `CLP_state` (0 idle, 1 busy) for the top level and ARM side.

Parameters:
- ADDR_W, 10, instruction memory address width (1024 entries).
- INSTR_W, 64, instruction word width.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- acc_enable  in  1  start request; sampled only in IDLE.
- instr_mem_en  out  1  BRAM read enable.
- instr_mem_addr  out  ADDR_W  BRAM read address.
- instr_port  in  INSTR_W  BRAM read data; valid 2 edges after the edge that raised `instr_mem_en`.
- instr_out  out  INSTR_W  instruction presented to the CLP.
- instr_valid  out  1  `instr_out` valid.
- instr_ready  in  1  CLP accepts `instr_out`.
- clp_done  in  1  one-cycle pulse: CLP finished its current instruction.
- CLP_state  out  1  0 idle, 1 busy.
- sched_done  out  1  one-cycle pulse at end of a program.
- instr_count  out  CNT_W  instructions issued in the current or last run.
- err_overflow  out  1  sticky: program ran past the last address without END.

Behaviour:
- Reset (`rst`=0, asynchronous, any state):
  - State goes to IDLE.
  - All outputs are 0, including `instr_out`, `instr_mem_addr`, `instr_count` and `err_overflow`.
  - Any in-flight handshake is dropped; no recovery is attempted.
- All outputs are registered.
- Instruction fields:
  - [63:60] opcode; 4'h0 = END, any other value is dispatched verbatim.
  - [59] sync bit.
  - The remaining bits are opaque to this block.
- IDLE:
  - If `acc_enable`=1: `instr_mem_addr`<=0, `instr_mem_en`<=1, `CLP_state`<=1, `instr_count`<=0, `err_overflow`<=0; go to FETCH.
- FETCH: `instr_mem_en`<=0; go to LATCH.
- LATCH: instruction register <= `instr_port`; go to DECODE.
- DECODE:
  - Opcode END: go to DONE.
  - Otherwise: `instr_out`<=instruction register, `instr_valid`<=1; go to ISSUE.
- ISSUE:
  - Hold `instr_out`/`instr_valid` stable until `instr_ready`=1 at an edge.
  - At that edge: `instr_valid`<=0, `instr_count`<=`instr_count`+1 (saturating at all-ones).
  - Then go to WAIT_DONE if sync=1, else NEXT.
- WAIT_DONE:
  - Stay until `clp_done`=1, then go to NEXT.
  - A `clp_done` pulse seen in any other state is ignored; it is not latched.
- NEXT:
  - If `instr_mem_addr` is all-ones: `err_overflow`<=1; go to DONE.
  - Else `instr_mem_addr`<=+1, `instr_mem_en`<=1; go to FETCH.
- DONE: `CLP_state`<=0, `sched_done`<=1 for one cycle; go to IDLE.
- `instr_count` and `err_overflow` hold their values in IDLE until the next start.
- Latency:
  - `acc_enable` sampled at edge e: `instr_valid` rises after edge e+3.
  - Handshake at edge h (no sync): next `instr_valid` rises after edge h+4.
  - `clp_done` at edge d in WAIT_DONE: next `instr_valid` rises after edge d+4.
- `acc_enable` is ignored while `CLP_state`=1; holding it high through DONE starts a new run from IDLE on the following edge.
- If `instr_ready` is already high when `instr_valid` rises, the handshake completes on the first ISSUE edge.
- `instr_mem_addr` holds its value outside NEXT and IDLE-start.

Test Plan:
- Three instructions: mem[0]=64'h1000_0000_0000_0001, mem[1]=64'h2000_0000_0000_0002, mem[2]=0; `instr_ready` tied 1; pulse `acc_enable`.
  -> Two dispatches in order, `instr_valid` first high 3 cycles after start, `instr_count`=2, one `sched_done` pulse, `CLP_state` 1 then 0.
- Backpressure: hold `instr_ready`=0 for 5 cycles after `instr_valid` rises.
  -> `instr_out` stable for all 5 cycles, `instr_count` unchanged until `instr_ready`=1.
- Sync: mem[0]=64'h1800_0000_0000_00AA, mem[1]=END; `clp_done` pulsed 7 cycles after the handshake.
  -> No `instr_mem_en` until `clp_done`; a `clp_done` pulse sent while in ISSUE has no effect.
- Overflow: all 1024 entries 64'h1000_0000_0000_0000.
  -> 1024 issues, `err_overflow`=1, `instr_mem_addr`=10'h3FF, `sched_done` pulse.
- Reset mid-run: assert `rst`=0 during ISSUE, asynchronously between edges.
  -> All outputs 0 immediately; after release, a new `acc_enable` restarts from address 0.
- `acc_enable` pulses while busy.
  -> Ignored; `instr_mem_addr` sequence unchanged.
